// File: rtl/axil_regbank.sv
// rtl/axil_regbank.sv - parametrised AXI4-Lite register bank with read-only status slots
// Define AXIL_REGBANK_WR_PULSE_EN to add the per-register wr_pulse commit strobe output.
module axil_regbank #(
  parameter int                C_S_AXI_DATA_WIDTH = 32,
  parameter int                N_REGS             = 8,
  parameter int                C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [N_REGS-1:0] RO_MASK            = '0
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]        S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]        S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  output logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [N_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in
`ifdef AXIL_REGBANK_WR_PULSE_EN
  ,
  output logic [N_REGS-1:0]                    wr_pulse
`endif
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int NB  = DW / 8;
  localparam int OFS = $clog2(NB);
  localparam int IW  = C_S_AXI_ADDR_WIDTH - OFS;

  logic          aw_full_q, aw_full_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic          w_full_q, w_full_d;
  logic [DW-1:0] w_data_q, w_data_d;
  logic [NB-1:0] w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] reg_q [N_REGS];
  logic [DW-1:0] reg_d [N_REGS];
  logic [N_REGS-1:0] hit_rw;

  logic          aw_hs, w_hs, ar_hs, commit, wr_in_range;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_strb;

  logic unused_sigs;
  assign unused_sigs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[OFS-1:0],
                         S_AXI_ARADDR[OFS-1:0], status_in};

  assign S_AXI_AWREADY = ~aw_full_q;
  assign S_AXI_WREADY  = ~w_full_q;
  assign S_AXI_ARREADY = ~rvalid_q | S_AXI_RREADY;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  // Write side: each half may come from its buffer or from a handshake on this very edge.
  always_comb begin
    aw_hs       = S_AXI_AWVALID & ~aw_full_q;
    w_hs        = S_AXI_WVALID & ~w_full_q;
    wr_idx      = aw_full_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFS];
    wr_data     = w_full_q ? w_data_q : S_AXI_WDATA;
    wr_strb     = w_full_q ? w_strb_q : S_AXI_WSTRB;
    commit      = (aw_full_q | aw_hs) & (w_full_q | w_hs) & (~bvalid_q | S_AXI_BREADY);
    wr_in_range = int'(wr_idx) < N_REGS;

    aw_full_d = commit ? 1'b0 : (aw_full_q | aw_hs);
    aw_idx_d  = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:OFS] : aw_idx_q;
    w_full_d  = commit ? 1'b0 : (w_full_q | w_hs);
    w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
    w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
    bvalid_d  = commit | (bvalid_q & ~S_AXI_BREADY);
    bresp_d   = commit ? (wr_in_range ? 2'b00 : 2'b10) : bresp_q;

    hit_rw = '0;
    for (int k = 0; k < N_REGS; k++) begin
      reg_d[k]  = reg_q[k];
      hit_rw[k] = commit && !RO_MASK[k] && (wr_idx == IW'(k));
      for (int j = 0; j < NB; j++) begin
        if (hit_rw[k] && wr_strb[j]) reg_d[k][j*8 +: 8] = wr_data[j*8 +: 8];
      end
    end
  end

  // Read side samples reg_q before any same-edge write lands.
  always_comb begin
    ar_hs    = S_AXI_ARVALID & (~rvalid_q | S_AXI_RREADY);
    rd_idx   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:OFS];
    rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rdata_d = '0;
      rresp_d = 2'b10;
      for (int k = 0; k < N_REGS; k++) begin
        if (rd_idx == IW'(k)) begin
          rresp_d = 2'b00;
          rdata_d = RO_MASK[k] ? status_in[k*DW +: DW] : reg_q[k];
        end
      end
    end
  end

  always_comb begin
    reg_out = '0;
    for (int k = 0; k < N_REGS; k++) reg_out[k*DW +: DW] = reg_q[k];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      for (int k = 0; k < N_REGS; k++) reg_q[k] <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      for (int k = 0; k < N_REGS; k++) reg_q[k] <= reg_d[k];
    end
  end

`ifdef AXIL_REGBANK_WR_PULSE_EN
  logic [N_REGS-1:0] wr_pulse_q, wr_pulse_d;

  always_comb wr_pulse_d = hit_rw;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) wr_pulse_q <= '0;
    else          wr_pulse_q <= wr_pulse_d;
  end

  assign wr_pulse = wr_pulse_q;
`endif

endmodule

// File: doc/axil_regbank.md
Name: axil_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4 x 32-bit mDC register slave.
- Generalised in register count and data width.
- Adds per-register read-only status mapping, byte-strobe writes, independent AW/W acceptance with back-pressure, and SLVERR on out-of-range access.
- Sits behind the AXI interconnect as a control/status block for PL logic.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; legal values 32 or 64.
- N_REGS, 8, number of registers; legal range 2..256.
- C_S_AXI_ADDR_WIDTH, 6, address width; must be at least clog2(N_REGS)+clog2(DW/8).
- RO_MASK, 0, N_REGS-bit mask; bit k=1 makes register k read-only, sourced from status_in.

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  AW handshake
- S_AXI_WDATA  in  DW  write data
- S_AXI_WSTRB  in  DW/8  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  W handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  B handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  AR handshake
- S_AXI_RDATA  out  DW  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  R handshake
- reg_out  out  N_REGS*DW  flat register contents; register k occupies bits [k*DW +: DW]
- status_in  in  N_REGS*DW  status values for RO registers; slots of RW registers ignored

Behaviour:
- Reset (async assert, sync release):
  - All registers 0.
  - AW/W buffers empty.
  - BVALID=0, RVALID=0, BRESP=RRESP=0, RDATA=0.
  - Any in-flight transaction is dropped; no response is issued afterwards.
- Decode:
  - idx = ADDR[C_S_AXI_ADDR_WIDTH-1 : clog2(DW/8)]; the low byte-offset bits are ignored.
  - idx >= N_REGS is out of range.
- Write channel:
  - AWREADY = ~aw_full; WREADY = ~w_full. The AW and W buffers each hold one entry and fill independently, in either order.
  - Commit occurs on the clock edge where both AW and W are available (buffered, or handshaking that same edge) AND (BVALID=0 or BREADY=1).
  - At commit, both buffers are cleared and BVALID=1 from the next cycle.
  - Latency: BVALID is high in the cycle after the later of the two handshakes, when B is not stalled.
  - If B is stalled, both buffers stay full and AWREADY/WREADY stay low until B completes.
  - In range, RW register: each byte lane j with WSTRB[j]=1 is updated. The new value is on reg_out in the same cycle BVALID rises. BRESP=OKAY.
  - In range, RO register: write ignored; BRESP=OKAY.
  - Out of range: write ignored; BRESP=SLVERR (2'b10).
  - BVALID and BRESP are held until BREADY is seen.
- Read channel:
  - ARREADY = ~RVALID | RREADY.
  - On an AR handshake, RDATA and RRESP are registered and RVALID=1 in the next cycle.
  - RDATA is held stable until the RREADY handshake.
  - RW register: returns its current value.
  - RO register: returns status_in sampled at the AR handshake edge.
  - Out of range: RDATA=0, RRESP=SLVERR.
  - Back-to-back reads with RREADY held at 1 sustain one read per cycle.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the pre-write value.
  - Read and write channels are fully independent.
- reg_out slots of RO registers always read 0.

Optional Feature:
- Macro: AXIL_REGBANK_WR_PULSE_EN.
- Defined: adds output port wr_pulse [N_REGS-1:0].
  - Bit k is high for exactly one cycle, the cycle BVALID rises, for a commit to in-range RW register k.
  - This holds even when WSTRB=0.
  - No pulse for RO or out-of-range writes.
- Undefined: the port does not exist and no pulse logic is generated.

Test Plan:
- Reset, then write 0x1,0x2,..,0x8 to addresses 0x00..0x1C with WSTRB=0xF, then read back -> all BRESP/RRESP=OKAY, read data 0x1..0x8, reg_out matches.
- Write 0xAABBCCDD to 0x04, then 0x11223344 with WSTRB=0x5 -> read returns 0xAA22CC44.
- Present W two cycles before AW, holding BREADY=0 for 3 cycles -> single commit, BVALID held 3 cycles. A second AW/W issued meanwhile is buffered, commits after B completes, and both AWREADY and WREADY are low while both buffers are full.
- RO_MASK=0x80, status_in slot 7=0xDEADBEEF: read 0x1C -> 0xDEADBEEF OKAY; write 0x1C -> OKAY, reg_out slot 7 stays 0. Read 0x20 with N_REGS=8 -> RDATA=0, RRESP=SLVERR; write 0x20 -> BRESP=SLVERR, no register changes.
- Assert ARESETN low for one cycle while RVALID=1 and a W is buffered -> RVALID, BVALID low; all registers 0; no stale B or R after release.
- With AXIL_REGBANK_WR_PULSE_EN defined, write to 0x08 -> wr_pulse=0x04 for one cycle aligned with BVALID. A write to 0x20 produces no pulse.
